// File: rtl/ncl_counter_sink_if.sv
// Ring-side (dual-rail data + completeness) and consumer-side (valid/ready word)
// signals of the NCL counter sink; the sink uses the slave modport.
interface ncl_counter_sink_if #(
    parameter int unsigned DIGITS = 32
);
    logic [2*DIGITS-1:0] sum;
    logic [DIGITS-1:0]   sumCOMP;
    logic [1:0]          carryout;
    logic                carryoutCOMP;
    logic [DIGITS-1:0]   value;
    logic                wrap;
    logic                valid;
    logic                ready;

    modport master (
        output sum, carryout, ready,
        input  sumCOMP, carryoutCOMP, value, wrap, valid
    );

    modport slave (
        input  sum, carryout, ready,
        output sumCOMP, carryoutCOMP, value, wrap, valid
    );
endinterface

// File: rtl/ncl_counter_sink.sv
// Clocked receiver of the dual-rail NCL counter ring: synchronizes the rails, runs the
// DATA/NULL completeness handshake and presents each word on valid/ready.
// Optional sequence checking is enabled by defining NCL_SINK_SEQCHECK_EN.
module ncl_counter_sink #(
    parameter int unsigned DIGITS      = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       init,
    ncl_counter_sink_if.slave          bus,
    output logic                       err,
    output logic                       seq_err
);
    localparam int unsigned RAILS = 2 * DIGITS + 2;

    typedef enum logic [1:0] {
        REQ_DATA = 2'd0,
        HOLD     = 2'd1,
        REQ_NULL = 2'd2
    } state_t;

    logic [RAILS-1:0]  sync_q [SYNC_STAGES];
    logic [RAILS-1:0]  rails;
    logic [DIGITS:0]   rail1;
    logic              data_complete;
    logic              null_complete;
    logic              illegal;
    logic              slot_free;
    logic              capture_c;
    logic              comp_d;

    state_t            state_q;
    state_t            state_d;
    logic              comp_q;
    logic [DIGITS-1:0] value_q;
    logic              wrap_q;
    logic              valid_q;
    logic              err_q;

    // Multi-flop synchronizer on every rail; carry-out rides as the top digit
    always_ff @(posedge clk) begin
        if (init) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= {bus.carryout, bus.sum};
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign rails = sync_q[SYNC_STAGES-1];

    // Completeness and illegal-code detection; an 11 digit is never DATA-complete
    always_comb begin
        data_complete = 1'b1;
        illegal       = 1'b0;
        rail1         = '0;
        null_complete = ~|rails;
        for (int unsigned i = 0; i < DIGITS + 1; i++) begin
            data_complete = data_complete & (rails[2*i+1] ^ rails[2*i]);
            illegal       = illegal | (rails[2*i+1] & rails[2*i]);
            rail1[i]      = rails[2*i+1];
        end
    end

    assign slot_free = ~valid_q | bus.ready;

    // State register
    always_ff @(posedge clk) begin
        if (init) begin
            state_q <= REQ_DATA;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            REQ_DATA: begin
                if (data_complete && slot_free) begin
                    state_d = REQ_NULL;
                end else if (data_complete) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (data_complete && slot_free) begin
                    state_d = REQ_NULL;
                end
            end
            REQ_NULL: begin
                if (null_complete) begin
                    state_d = REQ_DATA;
                end
            end
            default: state_d = REQ_DATA;
        endcase
    end

    // Output decode: capture strobe and next COMP level
    always_comb begin
        capture_c = 1'b0;
        comp_d    = 1'b0;
        if ((state_q == REQ_DATA) || (state_q == HOLD)) begin
            capture_c = data_complete & slot_free;
        end
        if (state_d == REQ_NULL) begin
            comp_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            comp_q  <= 1'b0;
            value_q <= '0;
            wrap_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            comp_q <= comp_d;
            if (illegal) begin
                err_q <= 1'b1;
            end
            if (capture_c) begin
                value_q <= rail1[DIGITS-1:0];
                wrap_q  <= rail1[DIGITS];
                valid_q <= 1'b1;
            end else if (valid_q && bus.ready) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef NCL_SINK_SEQCHECK_EN
    logic              have_prev_q;
    logic              seq_err_q;
    logic [DIGITS-1:0] value_exp;
    logic              wrap_exp;

    assign value_exp = DIGITS'(value_q + DIGITS'(1));
    assign wrap_exp  = &value_q;

    // Every capture after the first must be the successor of the previous word
    always_ff @(posedge clk) begin
        if (init) begin
            have_prev_q <= 1'b0;
            seq_err_q   <= 1'b0;
        end else if (capture_c) begin
            have_prev_q <= 1'b1;
            if (have_prev_q && ({wrap_exp, value_exp} != rail1)) begin
                seq_err_q <= 1'b1;
            end
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

    assign bus.sumCOMP      = {DIGITS{comp_q}};
    assign bus.carryoutCOMP = comp_q;
    assign bus.value        = value_q;
    assign bus.wrap         = wrap_q;
    assign bus.valid        = valid_q;
    assign err              = err_q;

endmodule

// File: doc/ncl_counter_sink.md
Name: ncl_counter_sink

Overview:
- Clocked receiving end of the dual-rail NCL counter ring.
- Consumes the DIGITS sum digits and the top-digit carry-out wavefronts, and returns completeness acknowledges (sumCOMP / carryoutCOMP) under the NCL four-phase DATA/NULL protocol.
- Each complete DATA wavefront is decoded to a binary word and presented to a synchronous consumer over a valid/ready handshake.
- Sits at the boundary between the asynchronous counter ring and the clocked test/observation logic.

Parameters:
- DIGITS, 32, number of dual-rail digits in the sum bus and in the decoded value.
- SYNC_STAGES, 2, synchronizer flops per input rail (minimum 2).

Ports:
- clk  input  1  system clock.
- init  input  1  synchronous active-high reset, sampled on the rising edge of clk.
- sum  input  2*DIGITS  dual-rail digits; digit i = {sum[2i+1], sum[2i]}.
  - rail1 = logical 1, rail0 = logical 0.
  - 00 = NULL, 01 = DATA 0, 10 = DATA 1, 11 = illegal.
- sumCOMP  output  DIGITS  completeness acknowledge to each sum digit; all bits always equal.
- carryout  input  2  dual-rail carry-out from the top digit; same encoding as sum.
- carryoutCOMP  output  1  completeness acknowledge to the carry-out; always equal to sumCOMP[0].
- value  output  DIGITS  decoded binary value of the last captured wavefront.
- wrap  output  1  decoded carry-out of the last captured wavefront.
- valid  output  1  value/wrap hold an unconsumed word.
- ready  input  1  consumer accepts the word when valid && ready at a clk edge.
- err  output  1  sticky illegal-code flag.
- seq_err  output  1  sticky sequence-mismatch flag (see Optional Feature).

Behaviour:
- Input synchronization:
  - Every rail of sum and carryout passes through SYNC_STAGES flops. Decode uses only the last stage.
  - Input-to-decision latency is SYNC_STAGES cycles.
- COMP polarity: COMP=0 requests DATA; COMP=1 requests NULL. All COMP outputs are registered.
- Reset (init=1): on the next edge the block enters REQ_DATA and drives COMP=0, valid=0, value=0, wrap=0, err=0, seq_err=0, and clears all sync flops. init asserted mid-wavefront abandons that wavefront.
- Completeness terms:
  - DATA-complete: every sum digit and carryout is exactly 01 or 10.
  - NULL-complete: every rail is 0.
  - slot_free: !valid || ready.
- State REQ_DATA (COMP=0):
  - DATA-complete && slot_free: capture the rail1 bits into value and carryout rail1 into wrap; set valid=1; COMP=1 on the same edge; go to REQ_NULL.
  - DATA-complete && !slot_free: go to HOLD.
  - Otherwise stay.
- State HOLD (COMP stays 0): the ring is stalled with DATA held on the wires. When slot_free, capture as in REQ_DATA and go to REQ_NULL.
- State REQ_NULL (COMP=1): when NULL-complete, set COMP=0 and go to REQ_DATA. Partial NULL means stay.
- Consumer handshake:
  - valid && ready at an edge clears valid, unless a capture occurs on the same edge.
  - Simultaneous consume and capture leaves valid=1 with the new word.
  - value and wrap are stable while valid=1 && ready=0.
- Illegal code:
  - Any digit or the carry at 11 in REQ_DATA or HOLD sets err=1 (sticky until init).
  - That sample counts as not DATA-complete, so no capture occurs.
  - 11 seen in REQ_NULL also sets err.
- Throughput: at most one word per DATA/NULL round trip. The minimum round trip is 2*SYNC_STAGES+2 cycles plus ring delay.

Optional Feature:
- Macro: NCL_SINK_SEQCHECK_EN.
- When defined:
  - Each capture after the first since init compares the new {wrap,value} with the expected next count: previous value + 1 mod 2^DIGITS, with wrap=1 exactly when the previous value was all ones.
  - A mismatch sets seq_err=1 (sticky until init). The word is still captured and presented.
- When undefined: seq_err is tied to 0 and no comparison logic exists.

Test Plan:
- Reset: assert init 1 cycle with random rail inputs -> next cycle COMP all 0, valid=0, value=0, err=0, seq_err=0.
- Single wavefront: drive DIGITS=32 DATA encoding 0x00000005 with carry DATA 0, ready=1 -> valid=1, value=0x00000005, wrap=0, and COMP=1 on the capture edge. Drive NULL -> COMP=0 within SYNC_STAGES+1 cycles.
- Backpressure: first word held with ready=0, then second DATA 0x00000006 arrives -> COMP stays 0 and value stays 0x5. Raise ready -> on the next edge value=0x6, valid=1, COMP=1.
- Illegal code: digit 7 driven 11 in REQ_DATA -> err=1 and no capture. Fix digit 7 to 01 -> capture proceeds and err stays 1.
- Wrap: DATA 0xFFFFFFFF then DATA 0x00000000 with carry 1 -> words 0xFFFFFFFF/wrap=0 then 0x00000000/wrap=1.
- Seq check with NCL_SINK_SEQCHECK_EN defined: capture 0x10 then 0x12 -> seq_err=1 after the second capture, value=0x12. Without the macro, the same stimulus leaves seq_err=0.
